// File: rtl/spi_flash_reader.sv
// spi_flash_reader: memory-side read responder that fetches 32-bit words from a SPI flash using the 03h read command.
module spi_flash_reader #(
    parameter int unsigned CLK_DIV = 1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:0] mem_addr,
    input  logic        mem_rstrb,
    output logic [31:0] mem_rdata,
    output logic        mem_done,
    output logic        spi_cs_no,
    output logic        spi_sck_o,
    output logic        spi_mosi_o,
    input  logic        spi_miso_i
);
    localparam int unsigned DW = $clog2(CLK_DIV + 1);
    typedef enum logic [1:0] {IDLE, SEND, RECV, DONE} state_e;
    state_e        state_q, state_d;
    logic [DW-1:0] div_q, div_d;
    logic [5:0]    bit_q, bit_d;
    logic          phase_q, phase_d;
    logic [31:0]   sh_q, sh_d, rx_q, rx_d, rdata_q, rdata_d;
    logic          done_q, done_d, cs_q, cs_d, sck_q, sck_d, mosi_q, mosi_d;
    logic          busy, tick, unused_addr;
    assign busy        = state_q == SEND || state_q == RECV;
    assign tick        = div_q == DW'(CLK_DIV - 1);
    assign unused_addr = ^mem_addr[31:24];
    assign mem_rdata   = rdata_q;
    assign mem_done    = done_q;
    assign spi_cs_no   = cs_q;
    assign spi_sck_o   = sck_q;
    assign spi_mosi_o  = mosi_q;
    // Pins are registered images of the current state, so they trail the FSM by one cycle.
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        phase_d = phase_q;
        sh_d    = sh_q;
        cs_d    = !busy;
        sck_d   = busy & phase_q;
        mosi_d  = (state_q == SEND) & sh_q[31];
        done_d  = state_q == DONE;
        rx_d    = (state_q == RECV && sck_d && !sck_q) ? {rx_q[30:0], spi_miso_i} : rx_q;
        rdata_d = (state_q == DONE) ? {rx_q[7:0], rx_q[15:8], rx_q[23:16], rx_q[31:24]} : rdata_q;
        case (state_q)
            IDLE: begin
                if (mem_rstrb && !done_q) begin
                    state_d = SEND;
                    sh_d    = {8'h03, mem_addr[23:0]};
                    div_d   = '0;
                    bit_d   = '0;
                    phase_d = 1'b0;
                end
            end
            SEND, RECV: begin
                div_d = tick ? '0 : div_q + 1'b1;
                if (tick) begin
                    phase_d = !phase_q;
                    if (phase_q) begin
                        sh_d    = {sh_q[30:0], 1'b0};
                        bit_d   = bit_q + 6'd1;
                        state_d = (bit_q == 6'd63) ? DONE : (bit_q == 6'd31) ? RECV : state_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            phase_q <= 1'b0;
            sh_q    <= '0;
            rx_q    <= '0;
            rdata_q <= '0;
            done_q  <= 1'b0;
            cs_q    <= 1'b1;
            sck_q   <= 1'b0;
            mosi_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            phase_q <= phase_d;
            sh_q    <= sh_d;
            rx_q    <= rx_d;
            rdata_q <= rdata_d;
            done_q  <= done_d;
            cs_q    <= cs_d;
            sck_q   <= sck_d;
            mosi_q  <= mosi_d;
        end
    end
endmodule

// File: tb/tb_spi_flash_reader.sv
// tb_spi_flash_reader: scoreboard bench with a behavioural SPI flash, covering CLK_DIV=1 and CLK_DIV=3 instances.
module tb_spi_flash_reader;
    logic        clk_i = 1'b0, rst_ni = 1'b0, rstrb = 1'b0, sel = 1'b0, fl_miso = 1'b0;
    logic [31:0] mem_addr = '0;
    logic [31:0] rdata1, rdata3, f_rdata, exp_w;
    logic        done1, done3, cs1, cs3, sck1, sck3, mosi1, mosi3;
    logic        f_done, f_cs, f_sck, f_mosi, rstrb1, rstrb3;
    logic        prev_cs = 1'b1, prev_sck = 1'b0, prev_mosi = 1'b0;
    logic [31:0] fl_cmd, fl_data;
    logic [31:0] exp_q[$];
    int total = 0, bad = 0, cyc = 0, done_cnt = 0, cs_low_cnt = 0, fl_cnt = 0;
    int min_gap = 1000, cs_high_run = 0, sck_run = 0, phase_err = 0, mosi_err = 0;

    always #5 clk_i = !clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    assign rstrb1  = rstrb & !sel;
    assign rstrb3  = rstrb & sel;
    assign f_done  = sel ? done3 : done1;
    assign f_rdata = sel ? rdata3 : rdata1;
    assign f_cs    = sel ? cs3 : cs1;
    assign f_sck   = sel ? sck3 : sck1;
    assign f_mosi  = sel ? mosi3 : mosi1;

    spi_flash_reader #(.CLK_DIV(1)) u1 (.clk_i(clk_i), .rst_ni(rst_ni), .mem_addr(mem_addr), .mem_rstrb(rstrb1),
        .mem_rdata(rdata1), .mem_done(done1), .spi_cs_no(cs1), .spi_sck_o(sck1), .spi_mosi_o(mosi1), .spi_miso_i(fl_miso));
    spi_flash_reader #(.CLK_DIV(3)) u3 (.clk_i(clk_i), .rst_ni(rst_ni), .mem_addr(mem_addr), .mem_rstrb(rstrb3),
        .mem_rdata(rdata3), .mem_done(done3), .spi_cs_no(cs3), .spi_sck_o(sck3), .spi_mosi_o(mosi3), .spi_miso_i(fl_miso));

    function automatic logic [7:0] fbyte(input logic [23:0] a);
        case (a)
            24'h000100: return 8'h11;
            24'h000101: return 8'h22;
            24'h000102: return 8'h33;
            24'h000103: return 8'h44;
            default:    return a[7:0] ^ a[15:8] ^ 8'h5A;
        endcase
    endfunction

    function automatic logic [31:0] exp_word(input logic [31:0] a);
        logic [23:0] b;
        b = a[23:0];
        return {fbyte(b + 24'd3), fbyte(b + 24'd2), fbyte(b + 24'd1), fbyte(b)};
    endfunction

    // Behavioural flash: shifts in command+address on SCK rise, drives data on SCK fall.
    always @(negedge f_cs) begin
        fl_cnt = 0;
        fl_cmd = '0;
    end
    always @(posedge f_sck) if (!f_cs) begin
        if (fl_cnt < 32) fl_cmd = {fl_cmd[30:0], f_mosi};
        fl_cnt++;
        if (fl_cnt == 32)
            fl_data = {fbyte(fl_cmd[23:0]), fbyte(fl_cmd[23:0] + 24'd1), fbyte(fl_cmd[23:0] + 24'd2), fbyte(fl_cmd[23:0] + 24'd3)};
    end
    always @(negedge f_sck) if (!f_cs && fl_cnt >= 32) begin
        fl_miso = fl_data[31];
        fl_data = {fl_data[30:0], 1'b0};
    end

    always @(negedge clk_i) begin
        if (f_done === 1'b1) begin
            done_cnt++;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL sb_unexpected_done rdata=%h", f_rdata);
            end else begin
                exp_w = exp_q.pop_front();
                if (f_rdata !== exp_w) begin
                    bad++;
                    $display("FAIL sb_rdata got=%h exp=%h", f_rdata, exp_w);
                end
            end
        end
        if (f_cs === 1'b0) cs_low_cnt++;
        if (f_cs === 1'b0 && prev_cs) begin
            if (cs_high_run < min_gap) min_gap = cs_high_run;
            cs_high_run = 0;
            sck_run = 1;
        end else if (f_cs === 1'b0) begin
            if (f_sck !== prev_sck) begin
                if (sck_run != (sel ? 3 : 1)) phase_err++;
                sck_run = 1;
            end else sck_run++;
        end else begin
            if (!prev_cs && sck_run != (sel ? 3 : 1)) phase_err++;
            cs_high_run++;
        end
        if (f_sck && !prev_sck && f_mosi !== prev_mosi) mosi_err++;
        prev_cs = f_cs;
        prev_sck = f_sck;
        prev_mosi = f_mosi;
    end

    task automatic start_read(input logic [31:0] a, output int acc);
        @(negedge clk_i);
        mem_addr = a;
        rstrb = 1'b1;
        exp_q.push_back(exp_word(a));
        acc = cyc + 1;
    endtask

    task automatic wait_done(output int dc);
        int n;
        n = 0;
        do begin
            @(negedge clk_i);
            n++;
        end while (f_done !== 1'b1 && n < 2000);
        total++;
        if (f_done !== 1'b1) begin
            bad++;
            $display("FAIL done_timeout got=0 required=1");
        end
        dc = cyc;
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk_i);
        total += 5;
        if (f_cs !== 1'b1) begin bad++; $display("FAIL rst_cs got=%b exp=1", f_cs); end
        if (f_sck !== 1'b0) begin bad++; $display("FAIL rst_sck got=%b exp=0", f_sck); end
        if (f_mosi !== 1'b0) begin bad++; $display("FAIL rst_mosi got=%b exp=0", f_mosi); end
        if (f_done !== 1'b0) begin bad++; $display("FAIL rst_done got=%b exp=0", f_done); end
        if (f_rdata !== 32'h0) begin bad++; $display("FAIL rst_rdata got=%h exp=0", f_rdata); end
        rst_ni = 1'b1;
        repeat (2) @(negedge clk_i);
    endtask

    task automatic test_basic;
        int acc, dc;
        sel = 1'b0;
        start_read(32'hFF000100, acc);
        wait_done(dc);
        total += 4;
        if (dc - acc != 129) begin bad++; $display("FAIL basic_latency got=%0d exp=129", dc - acc); end
        if (fl_cmd !== 32'h03000100) begin bad++; $display("FAIL basic_cmd got=%h exp=03000100", fl_cmd); end
        if (f_rdata !== 32'h44332211) begin bad++; $display("FAIL basic_rdata got=%h exp=44332211", f_rdata); end
        if (fl_cnt != 64) begin bad++; $display("FAIL basic_sck_rises got=%0d exp=64", fl_cnt); end
        rstrb = 1'b0;
        repeat (4) @(negedge clk_i);
    endtask

    task automatic test_div3;
        int acc, dc;
        sel = 1'b1;
        @(negedge clk_i);
        phase_err = 0;
        mosi_err = 0;
        start_read(32'hFF000100, acc);
        wait_done(dc);
        total += 4;
        if (dc - acc != 385) begin bad++; $display("FAIL div3_latency got=%0d exp=385", dc - acc); end
        if (f_rdata !== 32'h44332211) begin bad++; $display("FAIL div3_rdata got=%h exp=44332211", f_rdata); end
        rstrb = 1'b0;
        @(negedge clk_i);
        if (phase_err != 0) begin bad++; $display("FAIL div3_phase_len bad_phases=%0d exp=0", phase_err); end
        if (mosi_err != 0) begin bad++; $display("FAIL div3_mosi_stable changes=%0d exp=0", mosi_err); end
        repeat (4) @(negedge clk_i);
        sel = 1'b0;
        repeat (2) @(negedge clk_i);
    endtask

    task automatic test_held_strobe;
        int acc, dc, d0, l0;
        start_read(32'h00000100, acc);
        d0 = done_cnt;
        wait_done(dc);
        @(negedge clk_i);
        rstrb = 1'b0;
        l0 = cs_low_cnt;
        repeat (200) @(negedge clk_i);
        total += 2;
        if (done_cnt - d0 != 1) begin bad++; $display("FAIL held_done_pulses got=%0d exp=1", done_cnt - d0); end
        if (cs_low_cnt != l0) begin bad++; $display("FAIL held_extra_txn cs_low_cycles=%0d exp=0", cs_low_cnt - l0); end
    endtask

    task automatic test_back_to_back;
        int acc, d1, d2;
        min_gap = 1000;
        start_read(32'h00000000, acc);
        wait_done(d1);
        mem_addr = 32'h00000004;
        exp_q.push_back(exp_word(32'h00000004));
        wait_done(d2);
        rstrb = 1'b0;
        total += 2;
        if (d2 - d1 != 131) begin bad++; $display("FAIL b2b_spacing got=%0d exp=131", d2 - d1); end
        if (min_gap < 2) begin bad++; $display("FAIL b2b_cs_gap got=%0d exp>=2", min_gap); end
        repeat (4) @(negedge clk_i);
    endtask

    task automatic test_addr_change;
        int acc, dc;
        start_read(32'h00000100, acc);
        repeat (10) @(negedge clk_i);
        mem_addr = 32'h00ABCDEF;
        rstrb = 1'b0;
        wait_done(dc);
        total += 2;
        if (fl_cmd !== 32'h03000100) begin bad++; $display("FAIL addr_change_cmd got=%h exp=03000100", fl_cmd); end
        if (f_rdata !== 32'h44332211) begin bad++; $display("FAIL addr_change_rdata got=%h exp=44332211", f_rdata); end
        repeat (4) @(negedge clk_i);
    endtask

    task automatic test_reset_abort;
        int acc, dc, d0, n;
        start_read(32'h00000100, acc);
        n = 0;
        while (fl_cnt != 43 && n < 500) begin
            @(negedge clk_i);
            n++;
        end
        total++;
        if (fl_cnt != 43) begin bad++; $display("FAIL abort_reach_recv10 got=%0d exp=43", fl_cnt); end
        #2 rst_ni = 1'b0;
        #1;
        total += 4;
        if (f_cs !== 1'b1) begin bad++; $display("FAIL abort_cs got=%b exp=1", f_cs); end
        if (f_sck !== 1'b0) begin bad++; $display("FAIL abort_sck got=%b exp=0", f_sck); end
        if (f_rdata !== 32'h0) begin bad++; $display("FAIL abort_rdata got=%h exp=0", f_rdata); end
        if (f_done !== 1'b0) begin bad++; $display("FAIL abort_done got=%b exp=0", f_done); end
        exp_q.delete();
        rstrb = 1'b0;
        d0 = done_cnt;
        repeat (3) @(negedge clk_i);
        rst_ni = 1'b1;
        repeat (200) @(negedge clk_i);
        total++;
        if (done_cnt != d0) begin bad++; $display("FAIL abort_no_done got=%0d exp=0", done_cnt - d0); end
        start_read(32'h00000004, acc);
        wait_done(dc);
        rstrb = 1'b0;
        total++;
        if (dc - acc != 129) begin bad++; $display("FAIL abort_next_latency got=%0d exp=129", dc - acc); end
        repeat (4) @(negedge clk_i);
    endtask

    initial begin
        test_reset;
        test_basic;
        test_div3;
        test_held_strobe;
        test_back_to_back;
        test_addr_change;
        test_reset_abort;
        total++;
        if (exp_q.size() != 0) begin bad++; $display("FAIL sb_leftover got=%0d exp=0", exp_q.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
